// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state type and helpers for the 32-point SDF FFT controller
package fft_pkg;
  localparam int N_LOG2 = 5;
  localparam int N = 1 << N_LOG2;
  localparam int PIPE = 1;
  localparam int L = N - 1 + N_LOG2 * PIPE;
  localparam int TW = N_LOG2 - 1;
  localparam int CW = $clog2(L + 1) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  function automatic int stage_delay(input int k);
    return N >> (k + 1);
  endfunction
  function automatic int stage_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += stage_delay(j) + PIPE;
    return s;
  endfunction
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sdf_stage_seq.sv
// sdf_stage_seq: per-stage butterfly select and twiddle address derived from the master count
module sdf_stage_seq
  import fft_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [N_LOG2-1:0] mcnt,
  input  logic              act,
  output logic              bf_sel,
  output logic [TW-1:0]     tw_addr
);
  localparam logic [N_LOG2-1:0] OFF = N_LOG2'(stage_off(K));
  localparam logic [N_LOG2-1:0] MASK = N_LOG2'(stage_delay(K) - 1);
  logic [N_LOG2-1:0] c;
  assign c = mcnt - OFF;
  assign bf_sel = act & c[N_LOG2-1-K];
  assign tw_addr = (act & ~c[N_LOG2-1-K]) ? TW'((c & MASK) << K) : '0;
endmodule

// File: rtl/sdf_fft_ctrl.sv
// sdf_fft_ctrl: sequencer for the SDF radix-2 DIF FFT pipeline (handshake, advance, flush, stage selects, output index)
// Define BITREV_IDX_EN to report out_idx as the bit-reversed (true frequency bin) output count.
module sdf_fft_ctrl
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 shift_en,
  output logic                 flush,
  output logic [N_LOG2-1:0]    stage_act,
  output logic [N_LOG2-1:0]    bf_sel,
  output logic [N_LOG2*TW-1:0] tw_addr,
  output logic                 out_valid,
  output logic [N_LOG2-1:0]    out_idx,
  output logic                 frame_done
);
  localparam logic [CW-1:0] CMAX = '1;
  state_t state;
  logic [N_LOG2-1:0] mcnt, ocnt;
  logic [CW-1:0] sf, sl, tail, pend;
  logic [L-1:0] hist;
  logic accept, live, to_idle;
  // FLUSH is entered after every frame's last sample, so an accept at mcnt 0 continues seamlessly
  assign in_ready = state != FLUSH || mcnt == '0;
  assign accept = in_valid & in_ready;
  assign shift_en = state == FLUSH || in_valid;
  assign flush = state == FLUSH && !accept;
  assign out_valid = shift_en & hist[L-1];
  assign frame_done = out_valid && ocnt == '1;
  assign to_idle = state == FLUSH && !accept && pend == CW'(out_valid);
  assign live = state != IDLE || in_valid;
  assign tail = accept ? '0 : sl;
`ifdef BITREV_IDX_EN
  assign out_idx = bitrev(ocnt);
`else
  assign out_idx = ocnt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mcnt <= '0;
      ocnt <= '0;
      sf <= '0;
      sl <= '0;
      pend <= '0;
      hist <= '0;
    end else if (to_idle) begin
      state <= IDLE;
      mcnt <= '0;
      ocnt <= '0;
      sf <= '0;
      sl <= '0;
      pend <= '0;
      hist <= '0;
    end else begin
      if (accept) state <= (state != FLUSH && mcnt == '1) ? FLUSH : RUN;
      if (shift_en) begin
        mcnt <= mcnt + 1'b1;
        sf <= sf + CW'(sf != CMAX);
        sl <= tail + CW'(tail != CMAX);
        hist <= {hist[L-2:0], accept};
        pend <= pend + CW'(accept) - CW'(out_valid);
        ocnt <= ocnt + N_LOG2'(out_valid);
      end
    end
  // a stage is live from its offset after the first accept until the last sample's differences have left it
  for (genvar k = 0; k < N_LOG2; k++) begin : g_stage
    assign stage_act[k] = live && ({1'b0, sf} + 1'b1 > (CW+1)'(stage_off(k)))
                          && tail <= CW'(stage_off(k) + stage_delay(k));
    sdf_stage_seq #(.K(k)) u_seq (
      .mcnt   (mcnt),
      .act    (stage_act[k]),
      .bf_sel (bf_sel[k]),
      .tw_addr(tw_addr[k*TW +: TW])
    );
  end
endmodule

// File: doc/sdf_fft_ctrl.md
Name: sdf_fft_ctrl

Overview:
Central sequencer for the 32-point single-path delay-feedback (SDF) radix-2 DIF FFT pipeline. It generates the global advance enable for all delay lines and butterflies, and the per-stage butterfly/fill select. It also produces the twiddle ROM addresses, the flush/zero-insert control, the input handshake and output valid/index. It holds no datapath; the delay-line and butterfly blocks are slaves to its controls.

Parameters:
N_LOG2, 5, log2 of FFT size; N = 2**N_LOG2, stage k delay D_k = N >> (k+1)
PIPE, 1, register stages after each butterfly (counted in shift_en cycles)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample present on din this cycle
in_ready  out  1  controller accepts a sample this cycle (accept = in_valid & in_ready)
shift_en  out  1  global advance for every delay line / butterfly register
flush  out  1  datapath substitutes 0 for din while high
stage_act  out  N_LOG2  bit k: stage k holds valid frame data
bf_sel  out  N_LOG2  bit k: 0 = fill/pass phase, 1 = butterfly phase
tw_addr  out  N_LOG2*(N_LOG2-1)  packed per-stage twiddle index, stage k at [k*(N_LOG2-1) +: N_LOG2-1]
out_valid  out  1  FFT output sample valid on last stage
out_idx  out  N_LOG2  index of current output sample
frame_done  out  1  one-cycle pulse with last sample (index N-1) of a frame

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-high reset, rst. Reset clears all state immediately, including mid-frame, and discards partial frames.
- Reset values: every output 0, except in_ready = 1.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: in_ready=1, shift_en=in_valid, flush=0. First accept goes to RUN; that sample is index 0 and mcnt=0.
  - RUN: in_ready=1, shift_en=in_valid. If in_valid=0 mid-frame (accepted count mod N != 0), this is a stall: shift_en=0 and all state is frozen.
  - RUN -> FLUSH: in_valid=0 at a frame boundary with data still in flight.
  - FLUSH: shift_en=1, flush=1. in_ready=1 only on cycles where mcnt mod N == 0. An accept on such a cycle returns to RUN with flush=0 that cycle, and the new frame is seamless. FLUSH -> IDLE after the cycle carrying the last pending output.
- mcnt (N_LOG2-bit, wraps) increments on every shift_en cycle.
- Stage offsets: OFF_0 = 0, OFF_k = sum over j<k of (D_j + PIPE). Default values: 0, 17, 26, 31, 34.
- Local count: c_k = (mcnt - OFF_k) mod N.
  - bf_sel[k] = c_k[N_LOG2-1-k] when stage_act[k], else 0.
  - tw_addr_k = (c_k mod D_k) << k when stage_act[k] and bf_sel[k]=0, else 0.
- stage_act[k] sets OFF_k shift_en cycles after the first accept from IDLE. It clears once stage k has passed its last pending sample.
- Latency L = N-1 + N_LOG2*PIPE = 36 shift_en cycles from accept of sample 0 to out_valid with out_idx 0. Stall cycles do not count toward L.
- out_valid is high on exactly one shift_en cycle per accepted sample, L shift_en cycles after its accept. It is never high when shift_en=0.
- out_idx runs 0..N-1 per frame in output order. frame_done is out_valid with out_idx count = N-1.
- Boundary cases:
  - A partial frame followed by permanent in_valid=0 stalls indefinitely; there is no flush until the frame is complete.
  - Back-to-back frames: no bubbles, and out_valid stays high continuously after L.
  - in_valid while in_ready=0: not accepted, and the source must hold.
  - Counter wrap at N is modulo by construction.

Optional Feature:
BITREV_IDX_EN
- Defined: out_idx is the bit-reversed output count, i.e. the true frequency bin k of X[k].
- Undefined: out_idx is the natural output-order count 0..N-1.
- Timing and all other outputs are identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - constants N_LOG2, N, PIPE
  - function stage_delay(k) = N >> (k+1)
  - function stage_off(k)
  - FSM state typedef {IDLE, RUN, FLUSH}
  - bit-reverse function
- Sub-module sdf_stage_seq: derives c_k, bf_sel[k] and tw_addr_k from mcnt, the constant OFF_k and stage_act[k]. Instantiated N_LOG2 times by a generate loop. The top module holds the FSM, mcnt, the pending-sample counter and the output indexing.

Test Plan:
- Reset then 32 consecutive accepts -> bf_sel[0]=0 for cycles 0-15 and 1 for 16-31; first out_valid at shift_en cycle 36; out_idx 0..31; frame_done on the 32nd output; then FLUSH -> IDLE with stage_act=0.
- Stage 1 timing -> stage_act[1] rises at cycle 17; tw_addr_1 sequence 0,2,4,6,8,10,12,14 during its first fill phase.
- 3 back-to-back frames (96 accepts) -> out_valid continuous for 96 cycles starting at cycle 36, no flush until input stops.
- Frame of 10 samples, 5-cycle in_valid gap, 22 more samples -> shift_en=0 and all outputs frozen during the gap; first output at 36 + 5 = 41 clocks.
- In FLUSH, in_valid held high from mcnt=3 -> in_ready=0 until mcnt=0; accept there, flush drops the same cycle, and the new frame's out_idx restarts at 0 directly after frame_done.
- Assert rst mid-frame at sample 20 -> all outputs 0 and in_ready=1 asynchronously; next accept is treated as index 0. With BITREV_IDX_EN: out_idx sequence 0,16,8,24,4,...
